// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serialises one 48-bit SD command frame onto CMD, one bit per tick, then drives the N_CC gap.
// Define SD_CMD_CRC7_EN to generate CRC7 internally; otherwise bits 7..1 come from crc_in.
module sd_cmd_tx #(
    parameter int GAP_TICKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  crc_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, SEND = 2'd2, GAP = 2'd3;

    logic [1:0]  state;
    logic [47:0] frame;
    logic [5:0]  bit_cnt;
    logic [7:0]  gap_cnt;
    logic        tx_bit;
    logic        shifting;

    assign shifting = tick && (state == ARMED || state == SEND);

`ifdef SD_CMD_CRC7_EN
    logic [6:0] crc;
    logic       crc_phase;
    logic       fb;
    assign crc_phase = bit_cnt != 6'd0 && bit_cnt < 6'd8;
    assign fb        = frame[47] ^ crc[6];
    assign tx_bit    = crc_phase ? crc[6] : frame[47];

    // Bits 47..8 feed the LFSR as they go out; bits 7..1 drain it MSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc <= '0;
        else if (state == IDLE && start)
            crc <= '0;
        else if (shifting && bit_cnt >= 6'd8)
            crc <= {crc[5:0], 1'b0} ^ {3'b0, fb, 2'b0, fb};
        else if (shifting && crc_phase)
            crc <= {crc[5:0], 1'b0};
    end
`else
    assign tx_bit = frame[47];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            sd_cmd_out <= 1'b1;
            sd_cmd_oe  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // A tick coincident with acceptance is deliberately not consumed.
                    state   <= ARMED;
                    frame   <= {1'b0, 1'b1, cmd_index, cmd_arg, crc_in, 1'b1};
                    bit_cnt <= 6'd47;
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                end
                ARMED, SEND: if (tick) begin
                    state      <= bit_cnt == 6'd0 ? GAP : SEND;
                    sd_cmd_oe  <= 1'b1;
                    sd_cmd_out <= tx_bit;
                    frame      <= {frame[46:0], 1'b0};
                    bit_cnt    <= bit_cnt == 6'd0 ? 6'd0 : bit_cnt - 6'd1;
                    gap_cnt    <= '0;
                end
                GAP: if (tick) begin
                    if (gap_cnt == 8'(GAP_TICKS)) begin
                        state      <= IDLE;
                        sd_cmd_oe  <= 1'b0;
                        sd_cmd_out <= 1'b1;
                        done       <= 1'b1;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        gap_cnt    <= gap_cnt + 8'd1;
                        sd_cmd_out <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: scoreboard bench for sd_cmd_tx; instance a uses GAP_TICKS=8, instance b GAP_TICKS=0.
// Stimulus queues expected frames; a negedge monitor captures serial frames and checks them.
module tb_sd_cmd_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  tick_v = '0;
    logic [1:0]  start_v = '0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  crc_in = '0;
    logic [1:0]  ready_v, busy_v, done_v, out_v, oe_v;
    logic [1:0]  tick_q = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [47:0] exp_q[$];

    logic        act [2];
    int          n [2];
    logic [47:0] cap [2];
    logic        prev_ready [2];
    logic        prev_done [2];
    logic        prev_out [2];
    logic        prev_oe [2];

`ifdef SD_CMD_CRC7_EN
    localparam logic [47:0] CMD8_CRC0 = 48'h48000001AA87;
`else
    localparam logic [47:0] CMD8_CRC0 = 48'h48000001AA01;
`endif

    always #5 clk = ~clk;

    sd_cmd_tx #(.GAP_TICKS(8)) dut_a (
        .clk(clk), .reset(reset), .tick(tick_v[0]), .start(start_v[0]),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .crc_in(crc_in),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sd_cmd_out(out_v[0]), .sd_cmd_oe(oe_v[0])
    );

    sd_cmd_tx #(.GAP_TICKS(0)) dut_b (
        .clk(clk), .reset(reset), .tick(tick_v[1]), .start(start_v[1]),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .crc_in(crc_in),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sd_cmd_out(out_v[1]), .sd_cmd_oe(oe_v[1])
    );

    function automatic int gap_of(input int g);
        return g == 0 ? 8 : 0;
    endfunction

    function automatic int pattern(input int i);
        return i % 3 == 0 ? 1 : (i % 3 == 1 ? 3 : 7);
    endfunction

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int g, input int s);
        repeat (s - 1) cyc();
        tick_v[g] = 1'b1;
        cyc();
        tick_v[g] = 1'b0;
    endtask

    task automatic ticks(input int g, input int limit, input int sp);
        for (int i = 0; i < limit && busy_v[g]; i++)
            do_tick(g, sp == 0 ? pattern(i) : sp);
    endtask

    task automatic accept(input int g, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [6:0] crc, input logic [47:0] e, input logic with_tick);
        cmd_index = idx;
        cmd_arg   = arg;
        crc_in    = crc;
        exp_q.push_back(e);
        start_v[g] = 1'b1;
        tick_v[g]  = with_tick;
        cyc();
        start_v[g] = 1'b0;
        tick_v[g]  = 1'b0;
        cmd_index  = ~idx;
        cmd_arg    = ~arg;
        crc_in     = ~crc;
        check("accept", ready_v[g], 0);
    endtask

    task automatic finish_frame(input int g, input int sp);
        ticks(g, 80, sp);
        check("frame_complete", busy_v[g], 0);
    endtask

    task automatic send(input int g, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [6:0] crc, input logic [47:0] e, input int sp);
        accept(g, idx, arg, crc, e, 1'b0);
        finish_frame(g, sp);
    endtask

    task automatic check_idle(input int g);
        check("idle_ready", ready_v[g], 1);
        check("idle_busy", busy_v[g], 0);
        check("idle_done", done_v[g], 0);
        check("idle_out", out_v[g], 1);
        check("idle_oe", oe_v[g], 0);
    endtask

    always @(posedge clk) tick_q <= tick_v;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                act[g]        = 1'b0;
                n[g]          = 0;
                prev_ready[g] = 1'b1;
                prev_done[g]  = 1'b0;
                prev_out[g]   = 1'b1;
                prev_oe[g]    = 1'b0;
            end else begin
                if (prev_done[g]) check("done_pulse", done_v[g], 0);
                if (act[g]) begin
                    if (tick_q[g]) begin
                        n[g]++;
                        if (n[g] <= 48) cap[g] = {cap[g][46:0], out_v[g]};
                    end else
                        check("hold_between_ticks", {oe_v[g], out_v[g]}, {prev_oe[g], prev_out[g]});
                    if (done_v[g]) begin
                        check("done_tick", n[g], 49 + gap_of(g));
                        check("done_lines", {ready_v[g], oe_v[g], out_v[g]}, 3'b101);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got 0x%0h, want none", cap[g]);
                        end else
                            check("frame", cap[g], exp_q.pop_front());
                        act[g] = 1'b0;
                    end else if (n[g] > 48)
                        check("gap_level", {oe_v[g], out_v[g]}, 2'b11);
                    else
                        check("oe_window", oe_v[g], n[g] != 0);
                end else begin
                    check("no_stray_done", done_v[g], 0);
                    if (prev_ready[g] && !ready_v[g]) begin
                        act[g] = 1'b1;
                        n[g]   = 0;
                        cap[g] = '0;
                    end
                end
                prev_ready[g] = ready_v[g];
                prev_done[g]  = done_v[g];
                prev_out[g]   = out_v[g];
                prev_oe[g]    = oe_v[g];
            end
        end
    end

    initial begin
        repeat (3) cyc();
        check_idle(0);
        check_idle(1);
        reset = 1'b0;
        cyc();
        send(0, 6'd0,  32'h0,     7'h4A, 48'h400000000095, 4);
        send(0, 6'd8,  32'h1AA,   7'h43, 48'h48000001AA87, 4);
        send(0, 6'd17, 32'h0,     7'h2A, 48'h510000000055, 3);
        send(0, 6'd8,  32'h1AA,   7'h00, CMD8_CRC0,        2);
        // start during a frame is dropped; inputs differ so a wrong accept shows in the frame
        accept(0, 6'd17, 32'h0, 7'h2A, 48'h510000000055, 1'b0);
        ticks(0, 10, 4);
        cmd_index  = 6'h3F;
        cmd_arg    = 32'hFFFFFFFF;
        crc_in     = 7'h7F;
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        check("ignored_start", ready_v[0], 0);
        finish_frame(0, 4);
        accept(0, 6'd0, 32'h0, 7'h4A, 48'h400000000095, 1'b1);
        check("coincident_tick_oe", oe_v[0], 0);
        finish_frame(0, 4);
        // asynchronous reset in the middle of a frame
        accept(0, 6'd8, 32'h1AA, 7'h43, 48'h48000001AA87, 1'b0);
        ticks(0, 20, 2);
        reset = 1'b1;
        #1;
        check_idle(0);
        void'(exp_q.pop_back());
        cyc();
        reset = 1'b0;
        cyc();
        send(0, 6'd8, 32'h1AA, 7'h43, 48'h48000001AA87, 3);
        // zero gap, irregular tick spacing, back-to-back frames
        send(1, 6'd0,  32'h0,        7'h4A, 48'h400000000095, 0);
        send(1, 6'd17, 32'h0,        7'h2A, 48'h510000000055, 0);
        send(1, 6'd8,  32'h1AA,      7'h43, 48'h48000001AA87, 0);
        send(1, 6'd55, 32'hDEADBEEF, 7'h15, {2'b01, 6'd55, 32'hDEADBEEF, 7'h15, 1'b1}, 1);
        repeat (5) cyc();
        check("queue_drained", 48'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end
endmodule
